// File: rtl/rst_seq_ce_gen_if.sv
// Bundle of soft-reset/divider controls and per-channel reset/enable outputs.
// Combinational only; no latency of its own.
// No backpressure: all signals are level-valued, sampled every clk_i edge.
interface rst_seq_ce_gen_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
);
  logic                    soft_rst_i;
  logic [NUM_CH*DIV_W-1:0] div_i;
  logic [NUM_CH-1:0]       rst_no;
  logic [NUM_CH-1:0]       ce_o;
  logic                    ready_o;

  // Controller side: drives soft reset and divide values, observes resets/enables
  modport master (
    output soft_rst_i, div_i,
    input  rst_no, ce_o, ready_o
  );

  // Generator side
  modport slave (
    input  soft_rst_i, div_i,
    output rst_no, ce_o, ready_o
  );
endinterface

// File: rtl/rst_seq_ce_gen.sv
// Synchronises reset release, then releases NUM_CH resets in staggered order with per-channel CE ticks.
// rst_no[k] rises T_k = RST_CLK_CYCLES + k*STAGE_GAP edges after the synchronised release edge.
// No backpressure: soft_rst_i wins over any release edge; async rst_ni clears everything at once.
module rst_seq_ce_gen #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 16,
  parameter int RST_CLK_CYCLES = 1000,
  parameter int STAGE_GAP      = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int DIV_W          = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  rst_seq_ce_gen_if.slave   bus
);

  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(RST_CLK_CYCLES + (NUM_CH-1)*STAGE_GAP);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [SYNC_STAGES-1:0]        sync_q;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          soft_hold_q;
  logic                          cnt_en;
  logic [NUM_CH-1:0]             rst_q, rst_d;
  logic [NUM_CH-1:0]             ce_q, ce_d;
  logic [NUM_CH-1:0][DIV_W-1:0]  dcnt_q, dcnt_d;
  logic [NUM_CH-1:0][DIV_W-1:0]  div_q, div_d;

  // Reset-deassertion synchroniser; the last stage is the synchronised release
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  // Release counter, staggered reset release and sequencing FSM next state.
  // soft_hold_q delays counting by one edge so the edge that first samples
  // soft_rst_i low acts as the new synchronised release edge.
  always_comb begin
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    state_d = state_q;
    cnt_en  = sync_q[SYNC_STAGES-1] && !soft_hold_q && (state_q != ST_RUN) && (cnt_q != T_LAST);
    if (bus.soft_rst_i) begin
      cnt_d   = '0;
      rst_d   = '0;
      state_d = ST_ASSERT;
    end else begin
      if (cnt_en) cnt_d = cnt_q + CNT_W'(1);
      for (int k = 0; k < NUM_CH; k++) begin
        if (cnt_d >= CNT_W'(RST_CLK_CYCLES + k*STAGE_GAP)) rst_d[k] = 1'b1;
      end
      case (state_q)
        ST_ASSERT:  if (rst_d[0])        state_d = (&rst_d) ? ST_RUN : ST_RELEASE;
        ST_RELEASE: if (rst_d[NUM_CH-1]) state_d = ST_RUN;
        ST_RUN:                          state_d = ST_RUN;
        default:                         state_d = ST_ASSERT;
      endcase
    end
  end

  // Per-channel divider: count 0..div_q and wrap; CE is registered wrap; divide value reloads on release and wrap
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      dcnt_d[k] = '0;
      div_d[k]  = '0;
      ce_d[k]   = 1'b0;
      if (!bus.soft_rst_i) begin
        if (rst_q[k]) begin
          if (dcnt_q[k] == div_q[k]) begin
            ce_d[k]   = 1'b1;
            dcnt_d[k] = '0;
            div_d[k]  = bus.div_i[k*DIV_W +: DIV_W];
          end else begin
            dcnt_d[k] = dcnt_q[k] + DIV_W'(1);
            div_d[k]  = div_q[k];
          end
        end else if (rst_d[k]) begin
          div_d[k] = bus.div_i[k*DIV_W +: DIV_W];
        end
      end
    end
  end

  // State, counter, resets and dividers register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_ASSERT;
      cnt_q       <= '0;
      soft_hold_q <= 1'b0;
      rst_q       <= '0;
      ce_q        <= '0;
      dcnt_q      <= '0;
      div_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      soft_hold_q <= bus.soft_rst_i;
      rst_q       <= rst_d;
      ce_q        <= ce_d;
      dcnt_q      <= dcnt_d;
      div_q       <= div_d;
    end
  end

  assign bus.rst_no  = rst_q;
  assign bus.ce_o    = ce_q;
  assign bus.ready_o = (state_q == ST_RUN);

endmodule

// File: tb/tb_rst_seq_ce_gen.sv
// Self-checking bench: directed spec scenarios plus randomized soft/async resets and divider changes.
// Reference model works from release schedule (age since sync edge, per-channel wrap edge times).
// Outputs are sampled 1 time unit after each rising edge.
module tb_rst_seq_ce_gen;
  localparam int NUM_CH         = 3;
  localparam int CNT_W          = 16;
  localparam int RST_CLK_CYCLES = 10;
  localparam int STAGE_GAP      = 4;
  localparam int SYNC_STAGES    = 2;
  localparam int DIV_W          = 4;
  localparam int T_LAST         = RST_CLK_CYCLES + (NUM_CH-1)*STAGE_GAP;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;

  rst_seq_ce_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  rst_seq_ce_gen #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .RST_CLK_CYCLES(RST_CLK_CYCLES),
    .STAGE_GAP(STAGE_GAP), .SYNC_STAGES(SYNC_STAGES), .DIV_W(DIV_W)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  int edge_no   = 0;
  int since_rel = 0;
  int age       = -1;
  bit m_rel [NUM_CH];
  bit m_ce  [NUM_CH];
  int m_w   [NUM_CH];

  // observation bookkeeping for directed checks
  int base_edge = 0;
  int first_rst [NUM_CH];
  int first_ce  [NUM_CH];
  int first_rdy;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int t_of(int k);
    return RST_CLK_CYCLES + k*STAGE_GAP;
  endfunction

  function automatic int div_of(int k);
    logic [NUM_CH*DIV_W-1:0] v;
    v = bus.div_i;
    return int'(v[k*DIV_W +: DIV_W]);
  endfunction

  task automatic model_reset();
    since_rel = 0;
    age       = -1;
    for (int k = 0; k < NUM_CH; k++) begin
      m_rel[k] = 1'b0;
      m_ce[k]  = 1'b0;
      m_w[k]   = 0;
    end
  endtask

  // Advance the model by one rising edge using the inputs sampled on that edge
  task automatic model_step();
    edge_no++;
    if (!rst_ni) begin
      model_reset();
      return;
    end
    if (since_rel < 1000) since_rel++;
    if (bus.soft_rst_i) begin
      age = -1;
      for (int k = 0; k < NUM_CH; k++) begin
        m_rel[k] = 1'b0;
        m_ce[k]  = 1'b0;
      end
      return;
    end
    if (since_rel >= SYNC_STAGES) begin
      if (age < 0)           age = 0;
      else if (age < T_LAST) age = age + 1;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      bit now_rel;
      now_rel = (age >= t_of(k));
      m_ce[k] = 1'b0;
      if (m_rel[k] && now_rel) begin
        if (edge_no == m_w[k]) begin
          m_ce[k] = 1'b1;
          m_w[k]  = edge_no + div_of(k) + 1;
        end
      end else if (now_rel) begin
        m_w[k] = edge_no + div_of(k) + 1;
      end
      m_rel[k] = now_rel;
    end
  endtask

  function automatic logic [NUM_CH-1:0] exp_rst();
    logic [NUM_CH-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[k] = m_rel[k];
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_ce();
    logic [NUM_CH-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[k] = m_ce[k];
    return v;
  endfunction

  task automatic mark_origin();
    base_edge = edge_no;
    first_rdy = -1;
    for (int k = 0; k < NUM_CH; k++) begin
      first_rst[k] = -1;
      first_ce[k]  = -1;
    end
  endtask

  // One clock edge: advance model, compare all outputs, record first rises
  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
    check_eq("rst_no", 32'(bus.rst_no), 32'(exp_rst()));
    check_eq("ce_o",   32'(bus.ce_o),   32'(exp_ce()));
    check_eq("ready_o", 32'(bus.ready_o), 32'(age >= T_LAST));
    for (int k = 0; k < NUM_CH; k++) begin
      if (first_rst[k] < 0 && bus.rst_no[k]) first_rst[k] = edge_no - base_edge;
      if (first_ce[k] < 0 && bus.ce_o[k])    first_ce[k]  = edge_no - base_edge;
    end
    if (first_rdy < 0 && bus.ready_o) first_rdy = edge_no - base_edge;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic async_abort();
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_eq("abort_rst_no", 32'(bus.rst_no), 32'(0));
    check_eq("abort_ce_o",   32'(bus.ce_o),   32'(0));
    check_eq("abort_ready",  32'(bus.ready_o), 32'(0));
  endtask

  task automatic soft_pulse();
    bus.soft_rst_i = 1'b1;
    tick();
    bus.soft_rst_i = 1'b0;
  endtask

  initial begin
    int p0;
    int p1;
    int p2;
    bit seen;

    bus.soft_rst_i = 1'b0;
    bus.div_i      = {4'd5, 4'd0, 4'd2};
    model_reset();
    mark_origin();
    #2 rst_ni = 1'b0;

    // 1/2: power-on release and divider schedule
    ticks(3);
    rst_ni = 1'b1;
    mark_origin();
    ticks(40);
    check_eq("po_rst0", 32'(first_rst[0]), 32'(SYNC_STAGES + 10));
    check_eq("po_rst1", 32'(first_rst[1]), 32'(SYNC_STAGES + 14));
    check_eq("po_rst2", 32'(first_rst[2]), 32'(SYNC_STAGES + 18));
    check_eq("po_rdy",  32'(first_rdy),    32'(SYNC_STAGES + 18));
    check_eq("po_ce0",  32'(first_ce[0]),  32'(SYNC_STAGES + 13));
    check_eq("po_ce1",  32'(first_ce[1]),  32'(SYNC_STAGES + 15));
    check_eq("po_ce2",  32'(first_ce[2]),  32'(SYNC_STAGES + 24));

    // 3: async abort at E12, then full resync
    async_abort();
    ticks(2);
    rst_ni = 1'b1;
    mark_origin();
    ticks(SYNC_STAGES + 12);
    async_abort();
    ticks(2);
    rst_ni = 1'b1;
    mark_origin();
    ticks(30);
    check_eq("resync_rst0", 32'(first_rst[0]), 32'(SYNC_STAGES + 10));
    check_eq("resync_rdy",  32'(first_rdy),    32'(SYNC_STAGES + 18));

    // 4: soft reset in RUN, no sync delay on restart
    soft_pulse();
    check_eq("soft_run_clr", 32'({bus.rst_no, bus.ce_o, bus.ready_o}), 32'(0));
    mark_origin();
    ticks(30);
    check_eq("soft_rst0", 32'(first_rst[0]), 32'(11));
    check_eq("soft_rst1", 32'(first_rst[1]), 32'(15));
    check_eq("soft_rst2", 32'(first_rst[2]), 32'(19));

    // 5: soft reset held 20 cycles during RELEASE
    soft_pulse();
    ticks(13);
    bus.soft_rst_i = 1'b1;
    mark_origin();
    ticks(20);
    check_eq("soft_hold_rst", 32'(first_rst[0]), 32'(-1));
    bus.soft_rst_i = 1'b0;
    mark_origin();
    ticks(25);
    check_eq("soft_hold_rel", 32'(first_rst[0]), 32'(11));

    // 6: mid-period divider change on ch0 (2 -> 4)
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = bus.ce_o[0];
    end
    check_eq("ce0_seen", 32'(seen), 32'(1));
    p0 = edge_no;
    tick();
    bus.div_i[3:0] = 4'd4;
    p1 = -1;
    p2 = -1;
    for (int i = 0; i < 20 && p2 < 0; i++) begin
      tick();
      if (bus.ce_o[0]) begin
        if (p1 < 0) p1 = edge_no;
        else        p2 = edge_no;
      end
    end
    check_eq("div_cur_period", 32'(p1 - p0), 32'(3));
    check_eq("div_new_period", 32'(p2 - p1), 32'(5));

    // 6b: soft reset collides with ch1 release edge
    soft_pulse();
    ticks(14);
    bus.soft_rst_i = 1'b1;
    mark_origin();
    tick();
    check_eq("collide_rst1", 32'(bus.rst_no[1]), 32'(0));
    bus.soft_rst_i = 1'b0;
    ticks(10);
    check_eq("collide_never", 32'(first_rst[1]), 32'(-1));

    // Randomized: divider changes, soft pulses, async aborts
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 8) bus.div_i = NUM_CH*DIV_W'($urandom);
      if (r >= 90 && r < 93) bus.soft_rst_i = 1'b1;
      else                   bus.soft_rst_i = 1'b0;
      if (r == 99) begin
        async_abort();
        ticks(int'($urandom_range(1, 3)));
        rst_ni = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
